// File: rtl/core_mem_port.sv
// core_mem_port: per-core request front-end for the shared-memory crossbar.
// The core's load/store requests are queued in a small FIFO. One request at a
// time is presented to the crossbar and held until its ready arrives. Each
// completion comes back to the core as a tagged one-cycle response. The
// crossbar raises ready one cycle late, so after every grant a single DRAIN
// cycle swallows the duplicate ready before the next request is issued.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   req_valid/req_ready     core request handshake (ready = FIFO not full)
//   req_op                  {write,read}: 01 read, 10 write, 00/11 illegal
//   req_addr/wdata/tag      request payload
//   req_err                 one-cycle pulse: illegal op offered and dropped
//   resp_valid/tag/is_wr    one-cycle completion pulse with request tag
//   resp_rdata              read data (0 for writes)
//   mem_enable/addr/wr_data to this core's crossbar slices
//   mem_rd_data, mem_ready  from this core's crossbar slices
//   busy                    FIFO non-empty or FSM not IDLE
module core_mem_port #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              req_err,
    output logic              resp_valid,
    output logic [TAG_W-1:0]  resp_tag,
    output logic              resp_is_wr,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [1:0]        mem_enable,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_ready,
    output logic              busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [1:0]        op_q    [DEPTH];
    logic [ADDR_W-1:0] addr_q  [DEPTH];
    logic [DATA_W-1:0] wdata_q [DEPTH];
    logic [TAG_W-1:0]  tag_q   [DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    logic op_legal, push, pop;

    // req_ready looks only at the registered count, never at a same-cycle pop.
    assign req_ready = (count < CNT_W'(DEPTH));
    assign op_legal  = (req_op == 2'b01) || (req_op == 2'b10);
    assign push      = req_valid && req_ready && op_legal;
    // Ready only counts while a request is actually on the bus.
    assign pop       = (state == ISSUE) && mem_ready;
    assign busy      = (count != '0) || (state != IDLE);

    // NOTE: FIFO storage has no reset; entries are only read once count says
    // they were written, so clearing them would just cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            op_q[wr_ptr]    <= req_op;
            addr_q[wr_ptr]  <= req_addr;
            wdata_q[wr_ptr] <= req_wdata;
            tag_q[wr_ptr]   <= req_tag;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= IDLE;
        end else begin
            // Pointers are PTR_W bits wide, so they wrap modulo DEPTH.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            state <= state_nxt;
        end
    end

    // Response and error registers: one-cycle pulses, payload held between.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_err    <= 1'b0;
            resp_valid <= 1'b0;
            resp_tag   <= '0;
            resp_is_wr <= 1'b0;
            resp_rdata <= '0;
        end else begin
            req_err    <= req_valid && req_ready && !op_legal;
            resp_valid <= pop;
            if (pop) begin
                resp_tag   <= tag_q[rd_ptr];
                resp_is_wr <= op_q[rd_ptr][1];
                resp_rdata <= op_q[rd_ptr][1] ? '0 : mem_rd_data;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_nxt   = state;
        mem_enable  = 2'b00;
        mem_addr    = '0;
        mem_wr_data = '0;
        case (state)
            IDLE: begin
                if (count != '0) state_nxt = ISSUE;
            end
            ISSUE: begin
                // Head entry is stable here: it is only popped on mem_ready.
                mem_enable  = op_q[rd_ptr];
                mem_addr    = addr_q[rd_ptr];
                mem_wr_data = wdata_q[rd_ptr];
                if (mem_ready) state_nxt = DRAIN;
            end
            DRAIN: begin
                // count already reflects the pop from the grant cycle.
                state_nxt = (count != '0) ? ISSUE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_core_mem_port.sv
// Self-checking bench for core_mem_port: a behavioural crossbar responder
// plus a response scoreboard fed when requests are accepted.
module tb_core_mem_port;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int TAG_W  = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [1:0]        req_op = 2'b00;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic [TAG_W-1:0]  req_tag = '0;
    logic              req_err;
    logic              resp_valid;
    logic [TAG_W-1:0]  resp_tag;
    logic              resp_is_wr;
    logic [DATA_W-1:0] resp_rdata;
    logic [1:0]        mem_enable;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data = '0;
    logic              mem_ready = 1'b0;
    logic              busy;

    core_mem_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
        .req_err(req_err),
        .resp_valid(resp_valid), .resp_tag(resp_tag), .resp_is_wr(resp_is_wr),
        .resp_rdata(resp_rdata),
        .mem_enable(mem_enable), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data), .mem_ready(mem_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic              is_wr;
        logic [DATA_W-1:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_resp   = 0;

    logic [DATA_W-1:0] mem_arr [4096];   // what the crossbar memory holds
    logic [DATA_W-1:0] ref_mem [4096];   // expectation model, updated at push

    // Responder knobs.
    int latency     = 1;   // cycles of enable before ready
    bit withhold    = 0;   // contention: never grant
    bit force_ready = 0;   // drive ready high whenever not granting
    int wait_cnt    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Crossbar model: reacts to the post-edge enable, settles before negedge.
    always @(posedge clk) begin
        #2;
        if (reset) begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
        end else if (mem_enable != 2'b00 && !withhold) begin
            if (wait_cnt >= latency) begin
                mem_ready = 1'b1;
                wait_cnt  = 0;
                if (mem_enable == 2'b10) begin
                    mem_arr[mem_addr] = mem_wr_data;
                    mem_rd_data = 8'hFF;          // garbage: DUT must report 0
                end else begin
                    mem_rd_data = mem_arr[mem_addr];
                end
            end else begin
                mem_ready = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ready = force_ready;
            wait_cnt  = 0;
        end
    end

    // Scoreboard: every response must match the oldest expected entry.
    always @(negedge clk) begin
        if (resp_valid) begin
            n_resp++;
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 32'(resp_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_tag",   32'(resp_tag),   32'(e.tag));
                check("resp_is_wr", 32'(resp_is_wr), 32'(e.is_wr));
                check("resp_rdata", 32'(resp_rdata), 32'(e.rdata));
            end
        end
    end

    // Drive one request for one cycle; returns whether it was accepted.
    task automatic send(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input logic [TAG_W-1:0] tag,
                        output bit accepted);
        exp_t e;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_tag   = tag;
        accepted  = req_ready && (op == 2'b01 || op == 2'b10);
        if (accepted) begin
            e.tag   = tag;
            e.is_wr = op[1];
            if (op[1]) begin
                e.rdata = '0;
                ref_mem[addr] = wdata;
            end else begin
                e.rdata = ref_mem[addr];
            end
            exp_q.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 2'b00;
    endtask

    task automatic wait_empty(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !busy) break;
            @(negedge clk);
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        check("drain_not_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_req_ready"},  32'(req_ready),   32'd1);
        check({pfx, "_req_err"},    32'(req_err),     32'd0);
        check({pfx, "_resp_valid"}, 32'(resp_valid),  32'd0);
        check({pfx, "_resp_tag"},   32'(resp_tag),    32'd0);
        check({pfx, "_resp_is_wr"}, 32'(resp_is_wr),  32'd0);
        check({pfx, "_resp_rdata"}, 32'(resp_rdata),  32'd0);
        check({pfx, "_mem_enable"}, 32'(mem_enable),  32'd0);
        check({pfx, "_mem_addr"},   32'(mem_addr),    32'd0);
        check({pfx, "_mem_wdata"},  32'(mem_wr_data), 32'd0);
        check({pfx, "_busy"},       32'(busy),        32'd0);
    endtask

    initial begin
        bit acc;
        int n_acc;
        int base;
        bit found;
        int gap;

        for (int i = 0; i < 4096; i++) begin
            mem_arr[i] = 8'(i * 13 + 5);
        end
        mem_arr[12'h123] = 8'hA7;
        for (int i = 0; i < 4096; i++) ref_mem[i] = mem_arr[i];

        // Reset state.
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("rst");
        @(negedge clk);

        // Uncontested read: push at cycle 0, enable 2-3, response at 4.
        send(2'b01, 12'h123, 8'h00, 3'd5, acc);                 // now cycle 1
        check("t1_accept", 32'(acc), 32'd1);
        check("t1_en_c1", 32'(mem_enable), 32'd0);
        @(negedge clk);                                         // cycle 2
        check("t1_en_c2", 32'(mem_enable), 32'h1);
        check("t1_addr_c2", 32'(mem_addr), 32'h123);
        @(negedge clk);                                         // cycle 3
        check("t1_en_c3", 32'(mem_enable), 32'h1);
        check("t1_ready_c3", 32'(mem_ready), 32'd1);
        @(negedge clk);                                         // cycle 4
        check("t1_resp_c4", 32'(resp_valid), 32'd1);
        check("t1_en_c4", 32'(mem_enable), 32'd0);
        wait_empty(20);

        // Write then read same address; second enable 2 cycles after ready.
        send(2'b10, 12'h010, 8'h3C, 3'd1, acc);
        send(2'b01, 12'h010, 8'h00, 3'd2, acc);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (mem_ready && mem_enable != 2'b00) found = 1;
            else @(negedge clk);
        end
        check("t2_first_ready_seen", 32'(found), 32'd1);
        check("t2_first_is_write", 32'(mem_enable), 32'h2);
        gap = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            gap++;
            if (mem_enable != 2'b00) break;
        end
        check("t2_reissue_gap", 32'(gap), 32'd2);
        check("t2_second_is_read", 32'(mem_enable), 32'h1);
        check("t2_second_addr", 32'(mem_addr), 32'h010);
        wait_empty(30);

        // Five back-to-back pushes while ready is withheld.
        withhold = 1;
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_req_ready_%0d", i), 32'(req_ready), (i < DEPTH) ? 32'd1 : 32'd0);
            send(2'b01, 12'(12'h200 + i), 8'h00, 3'(i + 3), acc);
            if (acc) n_acc++;
        end
        check("t3_accepted", 32'(n_acc), 32'(DEPTH));
        check("t3_no_err", 32'(req_err), 32'd0);
        check("t3_held_en", 32'(mem_enable), 32'h1);
        base = n_resp;
        withhold = 0;
        wait_empty(100);
        check("t3_resp_count", 32'(n_resp - base), 32'(DEPTH));

        // Illegal op 11.
        req_valid = 1'b1;
        req_op    = 2'b11;
        req_tag   = 3'd7;
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 2'b00;
        check("t4_err_pulse", 32'(req_err), 32'd1);
        check("t4_not_busy", 32'(busy), 32'd0);
        check("t4_no_enable", 32'(mem_enable), 32'd0);
        @(negedge clk);
        check("t4_err_cleared", 32'(req_err), 32'd0);
        check("t4_no_enable2", 32'(mem_enable), 32'd0);

        // Ready held high through grant and DRAIN: one response per request.
        force_ready = 1;
        base = n_resp;
        send(2'b01, 12'h123, 8'h00, 3'd6, acc);
        send(2'b10, 12'h321, 8'h5A, 3'd0, acc);
        wait_empty(30);
        repeat (4) @(negedge clk);
        force_ready = 0;
        check("t5_one_resp_each", 32'(n_resp - base), 32'd2);

        // Contention then reset mid-ISSUE.
        withhold = 1;
        base = n_resp;
        send(2'b01, 12'h0AA, 8'h00, 3'd4, acc);
        send(2'b10, 12'h0BB, 8'h11, 3'd3, acc);
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t6_hold_%0d", i), 32'(mem_enable), 32'h1);
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
        check_reset_outputs("t6");
        reset = 1'b0;
        withhold = 0;
        repeat (6) @(negedge clk);
        check("t6_no_resp", 32'(n_resp - base), 32'd0);
        check("t6_idle_enable", 32'(mem_enable), 32'd0);
        check("t6_idle_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/core_mem_port.md
Name: core_mem_port

Overview:
- Per-core request front-end that sits directly upstream of the shared-memory crossbar. One instance drives one core's 2-bit enable slice, plus that core's addr and wr_data slices.
- Buffers the core's load/store requests in a small FIFO and presents one request at a time to the crossbar, holding it until the matching ready.
- Returns read data and completions to the core as tagged one-cycle responses.
- Absorbs the crossbar's one-cycle-late ready: after each ready it drains any duplicate grant before issuing the next request.

Parameters:
- ADDR_W, 12, address width: {bank id, word address}, same packing as the crossbar addr slice.
- DATA_W, 8, data word width (REG_SIZE).
- DEPTH, 4, request FIFO depth; power of two, at least 2.
- TAG_W, 3, core-supplied request tag width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  core presents a request
- req_ready  out  1  FIFO can accept a request (count < DEPTH)
- req_op  in  2  {write,read}: 01 = read, 10 = write; 00 and 11 illegal
- req_addr  in  ADDR_W  request address
- req_wdata  in  DATA_W  store data
- req_tag  in  TAG_W  request tag
- req_err  out  1  one-cycle pulse: an illegal op was offered and dropped
- resp_valid  out  1  one-cycle completion pulse
- resp_tag  out  TAG_W  tag of the completed request
- resp_is_wr  out  1  completed request was a write
- resp_rdata  out  DATA_W  read data; 0 for writes
- mem_enable  out  2  {write,read} to the crossbar enable slice
- mem_addr  out  ADDR_W  to the crossbar addr slice
- mem_wr_data  out  DATA_W  to the crossbar wr_data slice
- mem_rd_data  in  DATA_W  from the crossbar rd_data slice
- mem_ready  in  1  crossbar ready bit for this core
- busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset:
  - FIFO pointers and count go to 0; FSM goes to IDLE.
  - req_ready=1; req_err=0; resp_valid=0; resp_tag=0; resp_is_wr=0; resp_rdata=0; busy=0.
  - mem_enable=00, mem_addr=0, mem_wr_data=0.
  - Reset mid-ISSUE or mid-DRAIN discards all queued and in-flight requests; no response is produced for them.
- Enqueue:
  - A request is accepted when req_valid and req_ready are both high at the clock edge and req_op is 01 or 10.
  - req_ready is derived from the registered count only; it does not look ahead to a same-cycle pop.
  - If req_op is 00 or 11 with req_valid high, the request is not enqueued and req_err pulses in the next cycle.
  - If req_ready=0, the request is ignored and req_err stays 0.
  - A push and a pop in the same cycle are both performed; count is unchanged.
- FSM (registered state, 2 bits):
  - IDLE:
    - mem_enable=00.
    - Goes to ISSUE when count>0.
  - ISSUE:
    - mem_enable = op of the FIFO head; mem_addr and mem_wr_data come from the head entry.
    - Outputs are held stable until mem_ready is sampled high.
    - On mem_ready=1: capture mem_rd_data (reads) or 0 (writes) into the response registers; pulse resp_valid the next cycle with the head's tag and is_wr; pop the head; go to DRAIN.
  - DRAIN:
    - mem_enable=00, mem_addr=0, mem_wr_data=0.
    - mem_ready is ignored for exactly this cycle; it absorbs the duplicate grant caused by enable being held during the ready cycle.
    - Goes to ISSUE if count>0 after the pop, otherwise IDLE.
- Timing:
  - mem_ready is ignored in IDLE and DRAIN and never produces a response there.
  - Uncontested latency: push at cycle 0; ISSUE at cycle 2 (enable high); mem_ready at cycle 3; resp_valid at cycle 4.
  - Back-to-back queued requests: enable is asserted for a new request 2 cycles after the previous mem_ready.
  - Under bank contention, ISSUE holds indefinitely; there is no timeout.
- Ordering: responses are returned strictly in request order.
- FIFO pointers wrap modulo DEPTH.

Test Plan:
- Reset, then push read tag 5 addr 0x123 at cycle 0; bench memory asserts mem_ready at cycle 3 with rd_data 0xA7 -> mem_enable=01 during cycles 2-3; resp_valid at cycle 4 with tag 5, is_wr 0, rdata 0xA7; mem_enable=00 at cycle 4.
- Push write tag 1 (0x010, data 0x3C), then read tag 2 (0x010) -> first response is tag 1, is_wr 1, rdata 0; second is tag 2, rdata 0x3C; second enable rises exactly 2 cycles after the first ready.
- Push 5 requests back-to-back while memory withholds ready -> req_ready drops after 4 accepted; the 5th is ignored with no req_err; 4 responses return in order.
- req_op=11 with req_valid high -> req_err pulses 1 cycle; count unchanged; no mem_enable activity.
- mem_ready forced high in both the ready cycle and the DRAIN cycle -> exactly one resp_valid per request.
- Contention: ready withheld 6 cycles, then reset asserted mid-ISSUE -> all outputs return to reset values next cycle; no resp_valid; busy=0.
